// File: rtl/spi_pkg.sv
// spi_pkg: frame geometry and FSM state encoding shared by the SPI weight master and slave
package spi_pkg;
    localparam int NUM_CH     = 8;
    localparam int W_BITS     = 5;
    localparam int FRAME_BITS = 4 * NUM_CH * W_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_weight_master_if.sv
// spi_weight_master_if: host request/weight bus and SPI pins of the weight master
interface spi_weight_master_if;
    import spi_pkg::*;
    logic                       start;
    logic [NUM_CH*W_BITS-1:0]   w_cos_1;
    logic [NUM_CH*W_BITS-1:0]   w_sin_1;
    logic [NUM_CH*W_BITS-1:0]   w_cos_2;
    logic [NUM_CH*W_BITS-1:0]   w_sin_2;
    logic                       busy;
    logic                       done;
    logic                       sclk;
    logic                       mosi;
    logic                       ss;
    modport master (input start, w_cos_1, w_sin_1, w_cos_2, w_sin_2,
                    output busy, done, sclk, mosi, ss);
    modport slave  (output start, w_cos_1, w_sin_1, w_cos_2, w_sin_2,
                    input busy, done, sclk, mosi, ss);
endinterface

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: one-cycle tick every CLK_DIV cycles while enabled; phase restarts on disable
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_en,
    output logic o_tick
);
    logic [7:0] r_cnt;
    assign o_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= (!i_en || o_tick) ? '0 : r_cnt + 8'd1;
    end
endmodule

// File: rtl/spi_weight_master.sv
// spi_weight_master: serialises four packed weight buses as one SPI mode-0 frame
module spi_weight_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    spi_weight_master_if.master bus
);
    state_t                 r_state, w_next;
    logic [FRAME_BITS-1:0]  r_sh, w_frame;
    logic [CNT_W-1:0]       r_bits, w_bits;
    logic                   r_rdy, r_ss, r_sclk, r_mosi, r_busy, r_done;
    logic                   w_ss, w_sclk, w_mosi, w_load, w_adv, w_tick, w_last;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .i_en   (r_state != IDLE),
        .o_tick (w_tick)
    );

    assign w_frame = {bus.w_cos_1, bus.w_sin_1, bus.w_cos_2, bus.w_sin_2};
    assign w_last  = r_bits == CNT_W'(FRAME_BITS);

    // r_rdy holds off acceptance until the second edge after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (bus.start && r_rdy) ? SETUP : IDLE;
            SETUP:   w_next = w_tick ? SHIFT : SETUP;
            SHIFT:   w_next = (w_tick && !r_sclk && w_last) ? HOLD : SHIFT;
            HOLD:    w_next = w_tick ? GAP : HOLD;
            GAP:     w_next = w_tick ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
    end

    // outputs are decoded from the next state and registered so pins never see a comb path
    always_comb begin
        w_load = (r_state == IDLE) && (w_next == SETUP);
        w_adv  = (r_state == SHIFT) && w_tick && r_sclk && !w_last;
        w_ss   = (w_next == IDLE) || (w_next == GAP);
        w_sclk = (w_next == SHIFT) && ((r_state != SHIFT) || (r_sclk ^ w_tick));
        w_bits = (w_next != SHIFT) ? '0 : (w_sclk && !r_sclk) ? r_bits + 1'b1 : r_bits;
        w_mosi = w_load ? w_frame[FRAME_BITS-1] : w_adv ? r_sh[FRAME_BITS-2] : r_mosi;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ss   <= 1'b1;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_bits <= '0;
            r_sh   <= '0;
        end else begin
            r_ss   <= w_ss;
            r_sclk <= w_sclk;
            r_mosi <= w_mosi;
            r_busy <= !w_ss;
            r_done <= (r_state == HOLD) && w_tick;
            r_bits <= w_bits;
            r_sh   <= w_load ? w_frame : w_adv ? r_sh << 1 : r_sh;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.ss   = r_ss;
endmodule
